// File: rtl/svm_axi_regs_pkg.sv
// svm_axi_regs_pkg: register map, AXI response codes and channel FSM states for the SVM register file.
// SVM_AXI_IRQ_EN adds the IRQ register at word index 4.
`default_nettype none

package svm_axi_regs_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_RESULT = 3'd2;
  localparam logic [2:0] REG_STATE  = 3'd3;
  localparam logic [2:0] REG_IRQ    = 3'd4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  function automatic logic reg_mapped(input logic [2:0] idx);
`ifdef SVM_AXI_IRQ_EN
    return (idx <= REG_IRQ);
`else
    return (idx <= REG_STATE);
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/svm_axi_lite_regs_if.sv
// svm_axi_lite_regs_if: AXI4-Lite bus bundle with master/slave modports.
`default_nettype none

interface svm_axi_lite_regs_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   s_axi_awaddr;
  logic                s_axi_awvalid;
  logic                s_axi_awready;
  logic [DATA_W-1:0]   s_axi_wdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic                s_axi_wvalid;
  logic                s_axi_wready;
  logic [1:0]          s_axi_bresp;
  logic                s_axi_bvalid;
  logic                s_axi_bready;
  logic [ADDR_W-1:0]   s_axi_araddr;
  logic                s_axi_arvalid;
  logic                s_axi_arready;
  logic [DATA_W-1:0]   s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rvalid;
  logic                s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

`default_nettype wire

// File: rtl/svm_axi_wr_ch.sv
// svm_axi_wr_ch: AXI4-Lite write channel; latches AW and W independently, issues one commit
// strobe when both are held, then holds the B response until accepted.
`default_nettype none

module svm_axi_wr_ch
  import svm_axi_regs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   i_awaddr,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic                i_wvalid,
  output logic                o_wready,
  output logic [1:0]          o_bresp,
  output logic                o_bvalid,
  input  logic                i_bready,
  output logic                o_wr_en,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [DATA_W-1:0]   o_wr_data,
  output logic [DATA_W/8-1:0] o_wr_strb,
  input  logic                i_wr_err
);

  wr_state_t           r_state;
  wr_state_t           w_state_nxt;
  logic                r_live;
  logic                r_aw_got;
  logic                r_w_got;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [1:0]          r_bresp;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_commit;

  assign w_aw_hs  = i_awvalid && o_awready;
  assign w_w_hs   = i_wvalid && o_wready;
  // A beat arriving this cycle counts as held so AW+W together commit with no extra cycle.
  assign w_commit = (r_state == W_IDLE) && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= W_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      W_IDLE:  if (w_commit) w_state_nxt = W_RESP;
      W_RESP:  if (i_bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    o_awready = r_live && (r_state == W_IDLE) && !r_aw_got;
    o_wready  = r_live && (r_state == W_IDLE) && !r_w_got;
    o_bvalid  = (r_state == W_RESP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_live   <= 1'b0;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= AXI_RESP_OKAY;
    end else begin
      r_live <= 1'b1;
      if (w_commit) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
        r_bresp  <= i_wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end else begin
        if (w_aw_hs) begin
          r_aw_got <= 1'b1;
          r_awaddr <= i_awaddr;
        end
        if (w_w_hs) begin
          r_w_got <= 1'b1;
          r_wdata <= i_wdata;
          r_wstrb <= i_wstrb;
        end
      end
    end
  end

  assign o_wr_en   = w_commit;
  assign o_wr_addr = w_aw_hs ? i_awaddr : r_awaddr;
  assign o_wr_data = w_w_hs ? i_wdata : r_wdata;
  assign o_wr_strb = w_w_hs ? i_wstrb : r_wstrb;
  assign o_bresp   = r_bresp;

endmodule

`default_nettype wire

// File: rtl/svm_axi_lite_regs.sv
// svm_axi_lite_regs: AXI4-Lite register file for the SVM classifier (CTRL/STATUS/RESULT/STATE).
// Define SVM_AXI_IRQ_EN to add the IRQ register at 0x10 and the irq_o output.
`default_nettype none

module svm_axi_lite_regs
  import svm_axi_regs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  svm_axi_lite_regs_if.slave axi,
  output logic               start_o,
  input  logic               ready_i,
  input  logic [3:0]         cl_num_i,
  input  logic [3:0]         state_i
`ifdef SVM_AXI_IRQ_EN
  ,
  output logic               irq_o
`endif
);

  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;
  logic [DATA_W/8-1:0] w_wr_strb;
  logic [2:0]          w_wr_idx;
  logic                w_wr_err;
  logic                w_ctrl_we;
  logic                r_ctrl;

  svm_axi_wr_ch #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wr_ch (
    .clk       (clk),
    .reset     (reset),
    .i_awaddr  (axi.s_axi_awaddr),
    .i_awvalid (axi.s_axi_awvalid),
    .o_awready (axi.s_axi_awready),
    .i_wdata   (axi.s_axi_wdata),
    .i_wstrb   (axi.s_axi_wstrb),
    .i_wvalid  (axi.s_axi_wvalid),
    .o_wready  (axi.s_axi_wready),
    .o_bresp   (axi.s_axi_bresp),
    .o_bvalid  (axi.s_axi_bvalid),
    .i_bready  (axi.s_axi_bready),
    .o_wr_en   (w_wr_en),
    .o_wr_addr (w_wr_addr),
    .o_wr_data (w_wr_data),
    .o_wr_strb (w_wr_strb),
    .i_wr_err  (w_wr_err)
  );

  assign w_wr_idx  = w_wr_addr[4:2];
  assign w_wr_err  = !reg_mapped(w_wr_idx);
  assign w_ctrl_we = w_wr_en && (w_wr_idx == REG_CTRL) && w_wr_strb[0];

  always_ff @(posedge clk) begin
    if (!reset)         r_ctrl <= 1'b0;
    else if (w_ctrl_we) r_ctrl <= w_wr_data[0];
  end

  assign start_o = r_ctrl;

`ifdef SVM_AXI_IRQ_EN
  logic r_irq_en;
  logic r_irq_pend;
  logic r_ready_d;
  logic r_irq;
  logic w_irq_we;
  logic w_irq_set;

  assign w_irq_we  = w_wr_en && (w_wr_idx == REG_IRQ) && w_wr_strb[0];
  assign w_irq_set = ready_i && !r_ready_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_irq_en   <= 1'b0;
      r_irq_pend <= 1'b0;
      r_ready_d  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_ready_d <= ready_i;
      if (w_irq_we) r_irq_en <= w_wr_data[0];
      // A fresh completion wins over a simultaneous write-one-to-clear.
      if (w_irq_set)                    r_irq_pend <= 1'b1;
      else if (w_irq_we && w_wr_data[1]) r_irq_pend <= 1'b0;
      r_irq <= r_irq_en && r_irq_pend;
    end
  end

  assign irq_o = r_irq;
`endif

  rd_state_t         r_rd_state;
  rd_state_t         w_rd_state_nxt;
  logic              r_rd_live;
  logic              w_arready;
  logic              w_rvalid;
  logic              w_ar_hs;
  logic [2:0]        w_rd_idx;
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;

  assign w_ar_hs  = axi.s_axi_arvalid && w_arready;
  assign w_rd_idx = axi.s_axi_araddr[4:2];

  always_ff @(posedge clk) begin
    if (!reset) r_rd_state <= R_IDLE;
    else        r_rd_state <= w_rd_state_nxt;
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_ar_hs) w_rd_state_nxt = R_DATA;
      R_DATA:  if (axi.s_axi_rready) w_rd_state_nxt = R_IDLE;
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_arready = r_rd_live && (r_rd_state == R_IDLE);
    w_rvalid  = (r_rd_state == R_DATA);
  end

  always_comb begin
    w_rd_word = '0;
    case (w_rd_idx)
      REG_CTRL:   w_rd_word[0]   = r_ctrl;
      REG_STATUS: w_rd_word[0]   = ready_i;
      REG_RESULT: w_rd_word[3:0] = cl_num_i;
      REG_STATE:  w_rd_word[3:0] = state_i;
`ifdef SVM_AXI_IRQ_EN
      REG_IRQ:    w_rd_word[1:0] = {r_irq_pend, r_irq_en};
`endif
      default:    w_rd_word      = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_live <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= AXI_RESP_OKAY;
    end else begin
      r_rd_live <= 1'b1;
      if (w_ar_hs) begin
        r_rdata <= w_rd_word;
        r_rresp <= reg_mapped(w_rd_idx) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end
    end
  end

  assign axi.s_axi_arready = w_arready;
  assign axi.s_axi_rvalid  = w_rvalid;
  assign axi.s_axi_rdata   = r_rdata;
  assign axi.s_axi_rresp   = r_rresp;

  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, w_wr_addr[1:0], w_wr_data[DATA_W-1:1],
                         w_wr_strb[DATA_W/8-1:1], axi.s_axi_araddr[1:0]};

endmodule

`default_nettype wire
